serial_write: RTL
=================

Name: serial_write

Overview:
- UART transmitter: 8N1 framing (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
- Drives the board `tx` pin from bytes queued by user logic.
- Pairs with the existing `serial_read` receiver on CLOCK_24.
- A small FIFO absorbs bursts, so producers can write several bytes back-to-back without waiting on the line.

Parameters:
- CLK_FREQ, 24000000: input clock frequency in Hz.
- BAUD, 115200: line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer truncation, 208 at defaults): cycles per bit. Must be >= 2.
- DEPTH, 4: FIFO entries. Power of two, >= 2.

Ports:
- CLOCK_24  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  8  byte to queue.
- write  input  1  queue data_in this cycle (single-cycle strobe; held high = one byte per cycle).
- full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  one-cycle pulse when write is asserted while full.
- busy  output  1  high whenever the FIFO is non-empty or a frame is in progress.
- tx  output  1  serial line, idles high.

Behaviour:
- Reset (asynchronous on rst_n low, all registers):
  - Outputs: tx=1, full=0, overflow=0, busy=0.
  - FIFO empty; state IDLE; bit counter and baud counter = 0.
  - Mid-frame reset: the frame is aborted, tx returns to 1 immediately (asynchronously), and queued bytes are discarded.
- FIFO:
  - Write accepted at a rising edge when write=1 and full=0. full is the registered occupancy from before the edge.
  - Write with full=1: byte dropped, overflow=1 for the following cycle, FIFO contents unchanged. This includes the cycle in which the transmitter pops.
  - Pop and accept in the same cycle: occupancy unchanged.
  - Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy counter width is log2(DEPTH)+1.
- State machine (baud counter counts 0..CLKS_PER_BIT-1; each bit is held exactly CLKS_PER_BIT cycles):
  - IDLE:
    - tx=1.
    - If the FIFO is non-empty: pop the head into an 8-bit shift register, tx<=0, go to START.
    - Latency: a byte written at edge N into an empty FIFO while idle drives tx low at edge N+1.
  - START:
    - tx=0 for CLKS_PER_BIT cycles.
    - Then tx<=shift[0], bit counter=0, go to DATA.
  - DATA:
    - After each CLKS_PER_BIT cycles, shift right and increment the bit counter.
    - After bit 7 completes: tx<=1, go to STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - On completion, if the FIFO is non-empty: pop, tx<=0, go directly to START. No extra idle cycle.
    - Otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- busy:
  - Registered: 1 from the edge after a write is accepted.
  - Returns to 0 on the edge where STOP completes with an empty FIFO.
- tx is driven directly from a register (glitch-free).

Test Plan:
Benches use CLK_FREQ=1600, BAUD=100, so CLKS_PER_BIT=16.
- Reset values: hold rst_n=0 → tx=1, busy=0, full=0, overflow=0. Release with no writes for 100 cycles → tx stays 1.
- Single byte 0xA5 written at edge N:
  - tx=0 over cycles N+1..N+16.
  - Then bits 1,0,1,0,0,1,0,1 at 16 cycles each.
  - Stop bit 1 for 16 cycles.
  - busy falls at N+161.
- Burst 0x00, 0xFF, 0x55 on consecutive cycles → three contiguous 160-cycle frames with no idle gap; full never asserts (DEPTH=4).
- Overflow: write 6 bytes 0x01..0x06 on consecutive cycles while idle:
  - 0x01 is popped first, so 0x02..0x05 fill the FIFO and full=1.
  - The 0x06 write pulses overflow once.
  - Line carries 0x01..0x05 only.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x3C → tx=1 asynchronously. After release, tx stays idle and the queued bytes are not sent.
- Wrap-around: stream 10 bytes 0x10..0x19, writing each when full=0 → all ten appear on tx in order, with pointer wrap exercised twice.

Source files
------------

// File: rtl/serial_write_if.sv
// ---------------------------------------------------------------------------
// serial_write_if
// Byte-queue side of the serial_write UART transmitter.
//   data_in  : byte offered by the producer
//   write    : single-cycle strobe, queue data_in this cycle
//   full     : FIFO holds DEPTH entries, further writes are dropped
//   overflow : one-cycle pulse after a write that hit a full FIFO
//   busy     : FIFO non-empty or a frame is on the line
// master = producer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface serial_write_if;
   logic [7:0] data_in;
   logic       write;
   logic       full;
   logic       overflow;
   logic       busy;

   modport master (
      output data_in,
      output write,
      input  full,
      input  overflow,
      input  busy
   );

   modport slave (
      input  data_in,
      input  write,
      output full,
      output overflow,
      output busy
   );
endinterface

// File: rtl/serial_write.sv
// ---------------------------------------------------------------------------
// serial_write
// UART transmitter, 8N1 framing (start bit, 8 data bits LSB first, stop bit).
// A small FIFO absorbs bursts from the producer; frames queued back-to-back
// leave the line with no idle gap between them.
//   CLOCK_24 : system clock, rising edge
//   rst_n    : asynchronous active-low reset, aborts any frame in flight
//   bus      : serial_write_if.slave (data_in, write, full, overflow, busy)
//   tx       : serial line, idles high, driven straight from a register
// ---------------------------------------------------------------------------
module serial_write #(
   parameter int CLK_FREQ     = 24000000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
   parameter int DEPTH        = 4
) (
   input  logic          CLOCK_24,
   input  logic          rst_n,
   serial_write_if.slave bus,
   output logic          tx
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [BAUD_W-1:0] baud_cnt;
   logic [BAUD_W-1:0] baud_next;
   logic [2:0]        bit_cnt;
   logic [2:0]        bit_next;
   logic [7:0]        shift;
   logic [7:0]        shift_next;
   logic              tx_next;

   logic [7:0]        fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;

   logic              full_int;
   logic              fifo_empty;
   logic              accept;
   logic              pop;
   logic              bit_done;
   logic              overflow_reg;
   logic              busy_reg;
   logic              busy_next;

   // full comes from the registered occupancy, so a pop in the same cycle
   // does not open a slot for a write that arrives while full
   assign full_int   = (count == COUNT_FULL);
   assign fifo_empty = (count == '0);
   assign accept     = bus.write && !full_int;
   assign bit_done   = (baud_cnt == BAUD_LAST);
   assign count_next = count + CNT_W'(accept) - CNT_W'(pop);

   // busy looks ahead at the next occupancy and state so that it rises on
   // the accepting edge and falls on the edge where the last stop bit ends
   assign busy_next  = (count_next != '0) || (state_next != IDLE);

   assign bus.full     = full_int;
   assign bus.overflow = overflow_reg;
   assign bus.busy     = busy_reg;

   // FIFO storage, pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge CLOCK_24 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         if (accept) begin
            fifo_mem[wr_ptr] <= bus.data_in;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count        <= count_next;
         overflow_reg <= bus.write && full_int;
         busy_reg     <= busy_next;
      end
   end

   // Transmit state register; tx resets high at once so a frame cut short
   // by reset never leaves the line low
   always_ff @(posedge CLOCK_24 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_cnt  <= bit_next;
         shift    <= shift_next;
         tx       <= tx_next;
      end
   end

   // Next-state logic. Every bit lasts CLKS_PER_BIT cycles; tx is loaded one
   // edge ahead with the level of the bit that starts on that edge. STOP
   // chains straight into START when more data is queued so frames abut.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_cnt;
      shift_next = shift;
      tx_next    = tx;
      pop        = 1'b0;

      case (state)
         IDLE: begin
            tx_next   = 1'b1;
            baud_next = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = fifo_mem[rd_ptr];
               tx_next    = 1'b0;
               state_next = START;
            end
         end

         START: begin
            if (bit_done) begin
               baud_next  = '0;
               bit_next   = '0;
               tx_next    = shift[0];
               state_next = DATA;
            end else begin
               baud_next = baud_cnt + BAUD_W'(1);
            end
         end

         DATA: begin
            if (bit_done) begin
               baud_next = '0;
               if (bit_cnt == 3'd7) begin
                  tx_next    = 1'b1;
                  state_next = STOP;
               end else begin
                  shift_next = {1'b0, shift[7:1]};
                  tx_next    = shift[1];
                  bit_next   = bit_cnt + 3'd1;
               end
            end else begin
               baud_next = baud_cnt + BAUD_W'(1);
            end
         end

         STOP: begin
            if (bit_done) begin
               baud_next = '0;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_mem[rd_ptr];
                  tx_next    = 1'b0;
                  state_next = START;
               end else begin
                  tx_next    = 1'b1;
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_cnt + BAUD_W'(1);
            end
         end

         default: begin
            tx_next    = 1'b1;
            baud_next  = '0;
            state_next = IDLE;
         end
      endcase
   end

endmodule
